// File: rtl/i2c_target_responder_if.sv
// I2C target bus/local-side signal bundle.
//   scl_in, sda_in : bus levels seen by the target (asynchronous)
//   sda_oe         : target pull-low enable for SDA (open-drain)
//   tx_data/tx_taken : read data offered by local logic, and its latch pulse
//   rx_data/rx_valid : write data delivered to local logic, and its update pulse
//   addr_match, busy : transfer status
// The slave modport is used by the target; the master modport by whatever
// drives the bus and local side (an initiator, a bench).
interface i2c_target_responder_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] tx_data;
   logic       tx_taken;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       addr_match;
   logic       busy;

   modport slave (
      input  scl_in, sda_in, tx_data,
      output sda_oe, tx_taken, rx_data, rx_valid, addr_match, busy
   );

   modport master (
      output scl_in, sda_in, tx_data,
      input  sda_oe, tx_taken, rx_data, rx_valid, addr_match, busy
   );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target responder with a fixed 7-bit address.
// Ports:
//   clk   : system clock, at least 10x the SCL frequency
//   reset : synchronous active-high reset
//   bus   : i2c_target_responder_if.slave (bus pins plus local rx/tx handshake)
// SCL/SDA are synchronized, edges detected against a one-clock history, and
// SDA is only ever pulled low (sda_oe) or released.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in {addr[6:0], rw}
// ADDR_ACK  | pulling SDA low for the address ACK bit
// RX_DATA   | shifting in a write byte
// RX_ACK    | pulling SDA low for the data ACK bit
// TX_DATA   | presenting read byte bits on SCL falls
// TX_ACK    | SDA released, sampling the initiator's ACK/NACK
// WAIT_STOP | not addressed or NACKed; only START/STOP leave
module i2c_target_responder #(
   parameter logic [6:0] SLAVE_ADDR  = 7'b0110110,
   parameter int         SYNC_STAGES = 2
) (
   input logic                   clk,
   input logic                   reset,
   i2c_target_responder_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_prev, sda_prev, scl_cur, sda_cur;
   logic scl_rise, scl_fall, start_det, stop_det;

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic       rw, rw_nxt;
   // Set when the 8th bit of a byte has been sampled; the counter alone
   // cannot tell "byte complete" from "byte not started" since it wraps to 0.
   logic       full, full_nxt;
   logic       sda_oe_q, sda_oe_nxt;
   logic       addr_match_q, addr_match_nxt;
   logic [7:0] rx_data_q, rx_data_nxt;
   logic       rx_valid_q, rx_valid_nxt;
   logic       tx_taken_q, tx_taken_nxt;

   assign scl_cur = scl_sync[SYNC_STAGES-1];
   assign sda_cur = sda_sync[SYNC_STAGES-1];

   // Synchronizers reset to the idle bus level so reset release cannot fake an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
         scl_prev <= scl_cur;
         sda_prev <= sda_cur;
      end
   end

   assign scl_rise  =  scl_cur & ~scl_prev;
   assign scl_fall  = ~scl_cur &  scl_prev;
   assign start_det =  scl_cur &  scl_prev &  sda_prev & ~sda_cur;
   assign stop_det  =  scl_cur &  scl_prev & ~sda_prev &  sda_cur;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 3'd0;
         shreg        <= 8'h00;
         rw           <= 1'b0;
         full         <= 1'b0;
         sda_oe_q     <= 1'b0;
         addr_match_q <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         tx_taken_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         shreg        <= shreg_nxt;
         rw           <= rw_nxt;
         full         <= full_nxt;
         sda_oe_q     <= sda_oe_nxt;
         addr_match_q <= addr_match_nxt;
         rx_data_q    <= rx_data_nxt;
         rx_valid_q   <= rx_valid_nxt;
         tx_taken_q   <= tx_taken_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      shreg_nxt      = shreg;
      rw_nxt         = rw;
      full_nxt       = full;
      sda_oe_nxt     = sda_oe_q;
      addr_match_nxt = addr_match_q;
      rx_data_nxt    = rx_data_q;
      rx_valid_nxt   = 1'b0;
      tx_taken_nxt   = 1'b0;

      if (start_det) begin
         state_nxt      = ADDR;
         cnt_nxt        = 3'd0;
         full_nxt       = 1'b0;
         sda_oe_nxt     = 1'b0;
         addr_match_nxt = 1'b0;
      end else if (stop_det) begin
         state_nxt      = IDLE;
         cnt_nxt        = 3'd0;
         full_nxt       = 1'b0;
         sda_oe_nxt     = 1'b0;
         addr_match_nxt = 1'b0;
      end else begin
         case (state)
            ADDR, RX_DATA: begin
               if (scl_rise) begin
                  shreg_nxt = {shreg[6:0], sda_cur};
                  cnt_nxt   = cnt + 3'd1;
                  if (cnt == 3'd7) full_nxt = 1'b1;
               end else if (scl_fall && full) begin
                  full_nxt = 1'b0;
                  if (state == RX_DATA) begin
                     rx_data_nxt  = shreg;
                     rx_valid_nxt = 1'b1;
                     sda_oe_nxt   = 1'b1;
                     state_nxt    = RX_ACK;
                  end else if (shreg[7:1] == SLAVE_ADDR) begin
                     rw_nxt         = shreg[0];
                     sda_oe_nxt     = 1'b1;
                     addr_match_nxt = 1'b1;
                     state_nxt      = ADDR_ACK;
                  end else begin
                     sda_oe_nxt = 1'b0;
                     state_nxt  = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK, TX_ACK: begin
               if (state == TX_ACK && scl_rise && sda_cur) begin
                  state_nxt = WAIT_STOP;
               end else if (scl_fall) begin
                  cnt_nxt = 3'd0;
                  if (state == ADDR_ACK && !rw) begin
                     sda_oe_nxt = 1'b0;
                     state_nxt  = RX_DATA;
                  end else begin
                     shreg_nxt    = bus.tx_data;
                     tx_taken_nxt = 1'b1;
                     sda_oe_nxt   = ~bus.tx_data[7];
                     state_nxt    = TX_DATA;
                  end
               end
            end
            RX_ACK: begin
               if (scl_fall) begin
                  sda_oe_nxt = 1'b0;
                  cnt_nxt    = 3'd0;
                  state_nxt  = RX_DATA;
               end
            end
            TX_DATA: begin
               // shreg[7] is the bit on the wire; each fall moves to the next one.
               if (scl_fall) begin
                  if (cnt == 3'd7) begin
                     sda_oe_nxt = 1'b0;
                     cnt_nxt    = 3'd0;
                     state_nxt  = TX_ACK;
                  end else begin
                     sda_oe_nxt = ~shreg[6];
                     shreg_nxt  = {shreg[6:0], 1'b0};
                     cnt_nxt    = cnt + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sda_oe     = sda_oe_q;
   assign bus.addr_match = addr_match_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.tx_taken   = tx_taken_q;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_i2c_target_responder.sv
module tb_i2c_target_responder;
   localparam logic [6:0] SLAVE_ADDR = 7'b0110110;
   localparam int         Q          = 20;

   logic clk     = 1'b0;
   logic reset   = 1'b1;
   logic scl_drv = 1'b1;
   logic sda_drv = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   int rxv_cnt  = 0;
   int txt_cnt  = 0;
   int oe_cnt   = 0;
   int am_cnt   = 0;
   int both_cnt = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] last_rx_exp = 8'h00;

   i2c_target_responder_if bus();

   // Wired-AND bus: the initiator model and the target both only pull low.
   assign bus.scl_in = scl_drv;
   assign bus.sda_in = sda_drv & ~bus.sda_oe;

   i2c_target_responder #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rx_valid) begin
            rxv_cnt++;
            rx_q.push_back(bus.rx_data);
         end
         if (bus.tx_taken)                 txt_cnt++;
         if (bus.sda_oe)                   oe_cnt++;
         if (bus.addr_match)               am_cnt++;
         if (bus.rx_valid && bus.tx_taken) both_cnt++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- initiator model ----------------
   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_drv = 1'b1; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b1; wait_q();
   endtask

   task automatic bus_bit(input logic b, output logic seen);
      sda_drv = b;    wait_q();
      scl_drv = 1'b1; wait_q();
      seen = bus.sda_in;
      wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic recv_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] b);
      logic s;
      b = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         b[i] = s;
      end
      bus.tx_data = next_tx;
      bus_bit(~mack, s);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge clk);
      vectors++;
      if ({bus.sda_oe, bus.tx_taken, bus.rx_data, bus.rx_valid, bus.addr_match, bus.busy} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got oe=%b tt=%b rx=%h rv=%b am=%b busy=%b, required all 0",
                  bus.sda_oe, bus.tx_taken, bus.rx_data, bus.rx_valid, bus.addr_match, bus.busy);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy got %b required 0", bus.busy);
      end
   endtask

   task automatic test_write();
      logic ack;
      rxv_cnt = 0;
      bus_start();
      send_byte({SLAVE_ADDR, 1'b0}, ack);
      vectors++;
      if (ack !== 1'b1) begin miscompares++; $display("FAIL write_addr_ack: got %b required 1", ack); end
      vectors++;
      if (bus.addr_match !== 1'b1) begin miscompares++; $display("FAIL write_addr_match: got %b required 1", bus.addr_match); end
      send_byte(8'hA5, ack);
      vectors++;
      if (ack !== 1'b1) begin miscompares++; $display("FAIL write_data_ack: got %b required 1", ack); end
      vectors++;
      if (bus.addr_match !== 1'b1) begin miscompares++; $display("FAIL write_match_held: got %b required 1", bus.addr_match); end
      bus_stop();
      last_rx_exp = 8'hA5;
      vectors++;
      if (rxv_cnt !== 1) begin miscompares++; $display("FAIL write_rx_valid_count: got %0d required 1", rxv_cnt); end
      vectors++;
      if (bus.rx_data !== 8'hA5) begin miscompares++; $display("FAIL write_rx_data: got %h required a5", bus.rx_data); end
      vectors++;
      if ({bus.addr_match, bus.busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL write_after_stop: am=%b busy=%b required 0 0", bus.addr_match, bus.busy);
      end
   endtask

   task automatic test_mismatch();
      logic ack;
      rxv_cnt = 0; oe_cnt = 0; am_cnt = 0;
      bus_start();
      send_byte(8'h6E, ack);
      vectors++;
      if (ack !== 1'b0) begin miscompares++; $display("FAIL mismatch_addr_ack: got %b required 0", ack); end
      send_byte(8'hFF, ack);
      vectors++;
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mismatch_busy: got %b required 1", bus.busy); end
      bus_stop();
      vectors++;
      if (oe_cnt !== 0 || rxv_cnt !== 0 || am_cnt !== 0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mismatch_quiet: oe_clks=%0d rx_valid=%0d am_clks=%0d busy=%b required 0 0 0 0",
                  oe_cnt, rxv_cnt, am_cnt, bus.busy);
      end
   endtask

   task automatic test_read();
      logic ack;
      logic [7:0] b;
      txt_cnt = 0;
      bus.tx_data = 8'h3C;
      bus_start();
      send_byte({SLAVE_ADDR, 1'b1}, ack);
      vectors++;
      if (ack !== 1'b1) begin miscompares++; $display("FAIL read_addr_ack: got %b required 1", ack); end
      recv_byte(1'b1, 8'hC3, b);
      vectors++;
      if (b !== 8'h3C) begin miscompares++; $display("FAIL read_byte0: got %h required 3c", b); end
      recv_byte(1'b0, 8'h5A, b);
      vectors++;
      if (b !== 8'hC3) begin miscompares++; $display("FAIL read_byte1: got %h required c3", b); end
      vectors++;
      if ({bus.busy, bus.sda_oe} !== 2'b10) begin
         miscompares++;
         $display("FAIL read_wait_stop: busy=%b oe=%b required 1 0", bus.busy, bus.sda_oe);
      end
      vectors++;
      if (txt_cnt !== 2) begin miscompares++; $display("FAIL read_tx_taken_count: got %0d required 2", txt_cnt); end
      bus_stop();
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL read_idle: busy got %b required 0", bus.busy); end
   endtask

   task automatic test_repeated_start();
      logic ack;
      logic [7:0] b, r;
      rxv_cnt = 0; txt_cnt = 0;
      bus_start();
      send_byte({SLAVE_ADDR, 1'b0}, ack);
      send_byte(8'h11, ack);
      bus_start();
      last_rx_exp = 8'h11;
      vectors++;
      if (rxv_cnt !== 1 || bus.rx_data !== 8'h11) begin
         miscompares++;
         $display("FAIL rs_rx: count=%0d data=%h required 1 11", rxv_cnt, bus.rx_data);
      end
      r = 8'($urandom);
      bus.tx_data = r;
      send_byte({SLAVE_ADDR, 1'b1}, ack);
      vectors++;
      if (ack !== 1'b1 || bus.addr_match !== 1'b1) begin
         miscompares++;
         $display("FAIL rs_rematch: ack=%b am=%b required 1 1", ack, bus.addr_match);
      end
      recv_byte(1'b0, 8'h00, b);
      vectors++;
      if (txt_cnt !== 1 || b !== r) begin
         miscompares++;
         $display("FAIL rs_read: tx_taken=%0d byte=%h required 1 %h", txt_cnt, b, r);
      end
      bus_stop();
   endtask

   task automatic test_abort();
      logic ack, s;
      rxv_cnt = 0;
      bus_start();
      send_byte({SLAVE_ADDR, 1'b0}, ack);
      for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
      bus_stop();
      vectors++;
      if (rxv_cnt !== 0 || bus.rx_data !== last_rx_exp || bus.sda_oe !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort: rx_valid=%0d rx=%h oe=%b busy=%b required 0 %h 0 0",
                  rxv_cnt, bus.rx_data, bus.sda_oe, bus.busy, last_rx_exp);
      end
   endtask

   task automatic test_reset_mid();
      logic ack, s;
      bus.tx_data = 8'h00;
      bus_start();
      send_byte({SLAVE_ADDR, 1'b1}, ack);
      vectors++;
      if (bus.sda_oe !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_oe: got %b required 1", bus.sda_oe); end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.sda_oe, bus.tx_taken, bus.rx_data, bus.rx_valid, bus.addr_match, bus.busy} !== 13'd0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got oe=%b tt=%b rx=%h rv=%b am=%b busy=%b, required all 0",
                  bus.sda_oe, bus.tx_taken, bus.rx_data, bus.rx_valid, bus.addr_match, bus.busy);
      end
      last_rx_exp = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      oe_cnt = 0; am_cnt = 0;
      for (int i = 0; i < 6; i++) bus_bit(1'($urandom), s);
      vectors++;
      if (bus.busy !== 1'b0 || oe_cnt !== 0 || am_cnt !== 0) begin
         miscompares++;
         $display("FAIL rstmid_ignore: busy=%b oe_clks=%0d am_clks=%0d required 0 0 0", bus.busy, oe_cnt, am_cnt);
      end
      bus_stop();
   endtask

   // Reference model: a transfer is ACKed iff its 7-bit address equals
   // SLAVE_ADDR; matched writes deliver every byte, matched reads return the
   // offered bytes in order with one tx_taken per byte.
   task automatic test_back_to_back();
      logic ack, match, rw;
      logic [6:0] addr;
      logic [7:0] b, d;
      logic [7:0] txb[4];
      int len;
      rx_q.delete();
      exp_q.delete();
      for (int t = 0; t < 6; t++) begin
         match = 1'($urandom);
         addr  = match ? SLAVE_ADDR : 7'($urandom);
         if (!match && addr == SLAVE_ADDR) addr = ~SLAVE_ADDR;
         rw  = 1'($urandom);
         len = int'($urandom_range(1, 3));
         for (int i = 0; i < 4; i++) txb[i] = 8'($urandom);
         txt_cnt = 0;
         bus.tx_data = txb[0];
         bus_start();
         send_byte({addr, rw}, ack);
         vectors++;
         if (ack !== match) begin
            miscompares++;
            $display("FAIL b2b_addr_ack[%0d]: got %b required %b", t, ack, match);
         end
         if (!rw) begin
            for (int i = 0; i < len; i++) begin
               d = 8'($urandom);
               send_byte(d, ack);
               if (match) begin
                  exp_q.push_back(d);
                  last_rx_exp = d;
               end
               vectors++;
               if (ack !== match) begin
                  miscompares++;
                  $display("FAIL b2b_data_ack[%0d.%0d]: got %b required %b", t, i, ack, match);
               end
            end
         end else if (match) begin
            for (int i = 0; i < len; i++) begin
               recv_byte(i < len - 1, txb[i+1], b);
               vectors++;
               if (b !== txb[i]) begin
                  miscompares++;
                  $display("FAIL b2b_read[%0d.%0d]: got %h required %h", t, i, b, txb[i]);
               end
            end
            vectors++;
            if (txt_cnt !== len) begin
               miscompares++;
               $display("FAIL b2b_tx_taken[%0d]: got %0d required %0d", t, txt_cnt, len);
            end
         end
         bus_stop();
      end
      vectors++;
      if (rx_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL b2b_rx_count: got %0d required %0d", rx_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL b2b_rx[%0d]: got %h required %h", i, rx_q[i], exp_q[i]);
            end
         end
      end
      vectors++;
      if (bus.rx_data !== last_rx_exp) begin
         miscompares++;
         $display("FAIL b2b_last_rx: got %h required %h", bus.rx_data, last_rx_exp);
      end
      vectors++;
      if (both_cnt !== 0) begin
         miscompares++;
         $display("FAIL pulse_overlap: got %0d clks required 0", both_cnt);
      end
   endtask

   initial begin
      bus.tx_data = 8'h00;
      test_reset();
      test_write();
      test_mismatch();
      test_read();
      test_repeated_start();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
